segment_display_driver: RTL and testbench



---
 rtl/display_pkg.sv | 11 +
 rtl/hex_font_lut.sv | 9 +
 rtl/segment_display_driver.sv | 78 +++++++
 tb/tb_segment_display_driver.sv | 158 +++++++++++++++
 4 files changed

// File: rtl/display_pkg.sv
// display_pkg: shared state encoding, hex font and counter sizing for the 7-segment driver
package display_pkg;
    typedef enum logic [1:0] {IDLE, SHIFT, LATCH} state_t;
    localparam logic [6:0] FONT [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };
    function automatic int bit_cnt_w(input int digits);
        return $clog2(8 * digits);
    endfunction
endpackage

// File: rtl/hex_font_lut.sv
// hex_font_lut: one hex nibble to a-g segment pattern (bit0=a .. bit6=g)
module hex_font_lut
    import display_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg
);
    assign seg = FONT[nibble];
endmodule

// File: rtl/segment_display_driver.sv
// segment_display_driver: serialises a multi-digit 7-segment frame into a 74HC595 chain
module segment_display_driver
    import display_pkg::*;
#(
    parameter int DIGITS     = 3,
    parameter int CLKDIV     = 64,
    parameter bit ACTIVE_LOW = 1,
    parameter bit BLANK_LZ   = 0,
    parameter bit REFRESH    = 0
) (
    input  logic                  eclk,
    input  logic                  ereset,
    input  logic [4*DIGITS-1:0]   value,
    input  logic [DIGITS-1:0]     dp,
    input  logic                  load,
    output logic                  busy,
    output logic                  done,
    output logic                  rclk,
    output logic                  sclk,
    output logic                  ser
);
    localparam int N = 8 * DIGITS;
    localparam int W = bit_cnt_w(DIGITS);
    localparam logic [7:0] C_LAST = 8'(CLKDIV - 1);
    localparam logic [7:0] C_HALF = 8'(CLKDIV / 2);
    localparam logic [W-1:0] IDX_LAST = W'(N - 1);
    state_t state, state_n;
    logic [7:0] cnt;
    logic [W-1:0] idx;
    logic [N-1:0] frame, img;
    logic [6:0] seg [DIGITS];
    logic bit_end, latch_end, idle, accept;
    for (genvar d = 0; d < DIGITS; d++) begin : g_lut
        hex_font_lut u_lut (.nibble(value[4*d +: 4]), .seg(seg[d]));
    end
    always_comb begin
        logic run;
        run = BLANK_LZ;
        img = '0;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            run = run && value[4*i +: 4] == 4'd0 && i != 0;
            img[8*i +: 8] = {dp[i], run ? 7'd0 : seg[i]};
        end
    end
    assign bit_end   = cnt == C_LAST;
    assign latch_end = state == LATCH && cnt == C_HALF;
    assign idle      = state == IDLE || latch_end;
    assign accept    = idle && (load || REFRESH);
    always_comb begin
        state_n = idle ? (accept ? SHIFT : IDLE)
                : (state == SHIFT && bit_end && idx == IDX_LAST) ? LATCH : state;
    end
    always_ff @(posedge eclk) begin
        state <= ereset ? IDLE : state_n;
    end
    always_ff @(posedge eclk) begin
        if (ereset) begin
            cnt   <= '0;
            idx   <= '0;
            frame <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
            rclk  <= 1'b0;
            sclk  <= 1'b0;
            ser   <= 1'b0;
        end else begin
            busy  <= !idle;
            done  <= latch_end;
            rclk  <= state == LATCH && !latch_end;
            sclk  <= state == SHIFT && cnt >= C_HALF;
            if (state == SHIFT && cnt == 8'd0)
                ser <= frame[N-1] ^ ACTIVE_LOW;
            cnt   <= (idle || bit_end) ? 8'd0 : cnt + 8'd1;
            idx   <= idle ? '0 : (state == SHIFT && bit_end) ? idx + 1'b1 : idx;
            frame <= accept ? img : (state == SHIFT && bit_end) ? frame << 1 : frame;
        end
    end
endmodule

// File: tb/tb_segment_display_driver.sv
// tb_segment_display_driver: directed checks of framing, polarity, blanking, handshake, reset abort and refresh
module tb_segment_display_driver;
    logic eclk = 1'b0, ereset = 1'b1, load = 1'b0, load_r = 1'b0;
    logic [11:0] value = 12'h12F, value_r = 12'h12F;
    logic [2:0] dp = 3'b000;
    logic busy_a, done_a, rclk_a, sclk_a, ser_a;
    logic busy_b, done_b, rclk_b, sclk_b, ser_b;
    logic busy_c, done_c, rclk_c, sclk_c, ser_c;
    logic busy_r, done_r, rclk_r, sclk_r, ser_r;
    int checks = 0, failures = 0, t = 0, tg = 0;
    logic [23:0] sa, sb, sc, sr = '0, fr_r = '0;
    int na, t_rclk, t_done, n_done, t_bfall, t_busy1, n_rclk, base;
    int td_r = -1, p_r = -1, nfr = 0;
    logic psa, psb, psc, psr = 1'b0, prclk, pbusy;
    always #5 eclk = ~eclk;
    segment_display_driver #(.DIGITS(3), .CLKDIV(8), .ACTIVE_LOW(0), .BLANK_LZ(0), .REFRESH(0)) u_a (
        .eclk(eclk), .ereset(ereset), .value(value), .dp(dp), .load(load),
        .busy(busy_a), .done(done_a), .rclk(rclk_a), .sclk(sclk_a), .ser(ser_a));
    segment_display_driver #(.DIGITS(3), .CLKDIV(8), .ACTIVE_LOW(1), .BLANK_LZ(0), .REFRESH(0)) u_b (
        .eclk(eclk), .ereset(ereset), .value(value), .dp(dp), .load(load),
        .busy(busy_b), .done(done_b), .rclk(rclk_b), .sclk(sclk_b), .ser(ser_b));
    segment_display_driver #(.DIGITS(3), .CLKDIV(8), .ACTIVE_LOW(0), .BLANK_LZ(1), .REFRESH(0)) u_c (
        .eclk(eclk), .ereset(ereset), .value(value), .dp(dp), .load(load),
        .busy(busy_c), .done(done_c), .rclk(rclk_c), .sclk(sclk_c), .ser(ser_c));
    segment_display_driver #(.DIGITS(3), .CLKDIV(8), .ACTIVE_LOW(0), .BLANK_LZ(0), .REFRESH(1)) u_r (
        .eclk(eclk), .ereset(ereset), .value(value_r), .dp(3'b000), .load(load_r),
        .busy(busy_r), .done(done_r), .rclk(rclk_r), .sclk(sclk_r), .ser(ser_r));
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h expected=%h", tag, got, exp);
        end
    endtask
    task clear();
        sa = '0; sb = '0; sc = '0; na = 0; n_done = 0; n_rclk = 0;
        t_rclk = -1; t_done = -1; t_bfall = -1; t_busy1 = -1;
        psa = sclk_a; psb = sclk_b; psc = sclk_c; prclk = rclk_a; pbusy = busy_a;
    endtask
    task step();
        @(posedge eclk);
        #1;
        t++;
        tg++;
        if (sclk_a && !psa) begin sa = {sa[22:0], ser_a}; na++; end
        if (sclk_b && !psb) sb = {sb[22:0], ser_b};
        if (sclk_c && !psc) sc = {sc[22:0], ser_c};
        if (sclk_r && !psr) sr = {sr[22:0], ser_r};
        if (rclk_a && !prclk) begin n_rclk++; if (t_rclk < 0) t_rclk = t; end
        if (done_a) begin n_done++; if (t_done < 0) t_done = t; end
        if (busy_a && !pbusy && t_busy1 < 0) t_busy1 = t;
        if (!busy_a && pbusy && t_bfall < 0) t_bfall = t;
        if (done_r) begin
            if (td_r >= 0) p_r = tg - td_r;
            td_r = tg; fr_r = sr; sr = '0; nfr++;
        end
        psa = sclk_a; psb = sclk_b; psc = sclk_c; psr = sclk_r; prclk = rclk_a; pbusy = busy_a;
    endtask
    task launch();
        load = 1'b1;
        clear();
        t = -1;
        step();
        load = 1'b0;
    endtask
    task run_to(input int n);
        while (t < n) step();
    endtask
    task wait_nfr(input int n);
        for (int i = 0; i < 1000 && nfr < n; i++) step();
        if (nfr < n) check("refresh_timeout", nfr, n);
    endtask
    initial begin
        #1_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end
    initial begin
        repeat (3) step();
        check("reset_a", {busy_a, done_a, rclk_a, sclk_a, ser_a}, 5'b00000);
        check("reset_b", {busy_b, done_b, rclk_b, sclk_b, ser_b}, 5'b00000);
        ereset = 1'b0;
        step();
        value = 12'h12F; dp = 3'b000;
        launch();
        step();
        check("first_bit_a", {busy_a, sclk_a, ser_a}, 3'b100);
        check("first_bit_b", {busy_b, sclk_b, ser_b}, 3'b101);
        run_to(200);
        check("stream_a", sa, 24'h065B71);
        check("stream_b", sb, 24'hF9A48E);
        check("stream_c", sc, 24'h065B71);
        check("bit_count", na, 24);
        check("rclk_rise", t_rclk, 193);
        check("done_cycle", t_done, 197);
        check("done_count", n_done, 1);
        check("busy_rise", t_busy1, 1);
        check("busy_fall", t_bfall, 197);
        value = 12'h007;
        launch(); run_to(200);
        check("blz_007", sc, 24'h000007);
        check("noblz_007", sa, 24'h3F3F07);
        value = 12'h000;
        launch(); run_to(200);
        check("blz_000", sc, 24'h00003F);
        dp = 3'b110;
        launch(); run_to(200);
        check("blz_000_dp", sc, 24'h80803F);
        check("noblz_000_dp", sa, 24'hBFBF3F);
        dp = 3'b000;
        value = 12'h12F;
        launch();
        run_to(50);
        value = 12'h888;
        load = 1'b1;
        step();
        load = 1'b0;
        run_to(190);
        load = 1'b1;
        run_to(197);
        check("mid_stream", sa, 24'h065B71);
        check("mid_done", t_done, 197);
        check("mid_done_count", n_done, 1);
        check("ser_hold", ser_a, 1'b1);
        load = 1'b0;
        clear();
        t = 0;
        step();
        check("b2b_ser", {busy_a, sclk_a, ser_a}, 3'b100);
        run_to(200);
        check("b2b_stream", sa, 24'h7F7F7F);
        check("b2b_done", t_done, 197);
        td_r = -1; nfr = 0;
        wait_nfr(2);
        check("refresh_period", p_r, 197);
        check("refresh_frame", fr_r, 24'h065B71);
        value_r = 12'h3A0;
        base = nfr;
        wait_nfr(base + 1);
        check("refresh_inflight", fr_r, 24'h065B71);
        wait_nfr(base + 2);
        check("refresh_new", fr_r, 24'h4F773F);
        check("refresh_period2", p_r, 197);
        value = 12'h12F;
        launch();
        run_to(99);
        ereset = 1'b1;
        step();
        check("abort_reset", {busy_a, done_a, rclk_a, sclk_a, ser_a}, 5'b00000);
        ereset = 1'b0;
        run_to(260);
        check("abort_rclk", n_rclk, 0);
        check("abort_done", n_done, 0);
        check("abort_busy", busy_a, 1'b0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
